// File: rtl/gyro_spi_reader.sv
// Periodic SPI mode-0 burst reader for a gyro: reads XH..ZL and presents signed rate samples.
// Optional bias calibration when GYRO_BIAS_EN is defined (first 16 frames averaged, then subtracted).
module gyro_spi_reader #(
    parameter int         SCLK_DIV      = 50,
    parameter int         SAMPLE_PERIOD = 100000,
    parameter logic [7:0] REG_ADDR      = 8'h43
) (
    input  logic               clk_100mhz,
    input  logic               rst_n_in,
    input  logic               enable_in,
    output logic               spi_cs_n_out,
    output logic               spi_sclk_out,
    output logic               spi_mosi_out,
    input  logic               spi_miso_in,
    output logic signed [15:0] gx_out,
    output logic signed [15:0] gy_out,
    output logic signed [15:0] gz_out,
    output logic               valid_out,
    output logic               busy_out,
    output logic               cal_done_out
);
    localparam int DIV_W = $clog2(SCLK_DIV + 1);
    localparam int TMR_W = $clog2(SAMPLE_PERIOD + 1);

    typedef enum logic [2:0] {IDLE, CS_SETUP, XFER, CS_HOLD, DONE} state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [DIV_W-1:0]   r_div;
    logic [5:0]         r_bit;
    logic [55:0]        r_tx;
    logic [47:0]        r_rx;
    logic               r_cs_n;
    logic               r_sclk;
    logic               r_mosi;
    logic               r_valid;
    logic               r_busy;
    logic signed [15:0] r_gx;
    logic signed [15:0] r_gy;
    logic signed [15:0] r_gz;

    logic               w_tick;
    logic               w_div_end;
    logic signed [15:0] w_raw_x;
    logic signed [15:0] w_raw_y;
    logic signed [15:0] w_raw_z;

    assign w_tick    = enable_in && (r_timer == TMR_W'(SAMPLE_PERIOD - 1));
    assign w_div_end = (r_div == DIV_W'(SCLK_DIV - 1));
    assign w_raw_x   = r_rx[47:32];
    assign w_raw_y   = r_rx[31:16];
    assign w_raw_z   = r_rx[15:0];

`ifdef GYRO_BIAS_EN
    logic [3:0]         r_cal_cnt;
    logic               r_cal_done;
    logic signed [19:0] r_acc_x;
    logic signed [19:0] r_acc_y;
    logic signed [19:0] r_acc_z;
    logic signed [15:0] w_bias_x;
    logic signed [15:0] w_bias_y;
    logic signed [15:0] w_bias_z;

    // The mean of sixteen 16-bit samples always fits back into 16 bits
    assign w_bias_x = 16'(r_acc_x >>> 4);
    assign w_bias_y = 16'(r_acc_y >>> 4);
    assign w_bias_z = 16'(r_acc_z >>> 4);
    assign cal_done_out = r_cal_done;

    function automatic logic signed [15:0] subSat(input logic signed [15:0] raw,
                                                  input logic signed [15:0] bias);
        logic signed [16:0] diff;
        diff = 17'(raw) - 17'(bias);
        if (diff > 17'sd32767) return 16'sh7FFF;
        else if (diff < -17'sd32768) return 16'sh8000;
        return diff[15:0];
    endfunction
`else
    assign cal_done_out = rst_n_in;
`endif

    assign spi_cs_n_out = r_cs_n;
    assign spi_sclk_out = r_sclk;
    assign spi_mosi_out = r_mosi;
    assign gx_out       = r_gx;
    assign gy_out       = r_gy;
    assign gz_out       = r_gz;
    assign valid_out    = r_valid;
    assign busy_out     = r_busy;

    always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_timer <= '0;
        end else if (enable_in) begin
            r_timer <= w_tick ? '0 : r_timer + TMR_W'(1);
        end
    end

    // Ticks outside IDLE are simply ignored, so an overlong frame drops the next sample slot
    always_ff @(posedge clk_100mhz or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_gx    <= '0;
            r_gy    <= '0;
            r_gz    <= '0;
`ifdef GYRO_BIAS_EN
            r_cal_cnt  <= '0;
            r_cal_done <= 1'b0;
            r_acc_x    <= '0;
            r_acc_y    <= '0;
            r_acc_z    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_valid <= 1'b0;
                    if (w_tick) begin
                        r_state <= CS_SETUP;
                        r_cs_n  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_div   <= '0;
                        r_bit   <= '0;
                        r_tx    <= {REG_ADDR | 8'h80, 48'h0};
                    end
                end
                CS_SETUP: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= XFER;
                        r_mosi  <= r_tx[55];
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                XFER: begin
                    if (w_div_end) begin
                        r_div <= '0;
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                            r_rx   <= {r_rx[46:0], spi_miso_in};
                        end else begin
                            r_sclk <= 1'b0;
                            if (r_bit == 6'd55) begin
                                r_state <= CS_HOLD;
                                r_mosi  <= 1'b0;
                            end else begin
                                r_bit  <= r_bit + 6'd1;
                                r_tx   <= {r_tx[54:0], 1'b0};
                                r_mosi <= r_tx[54];
                            end
                        end
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                CS_HOLD: begin
                    if (w_div_end) begin
                        r_div   <= '0;
                        r_state <= DONE;
                        r_cs_n  <= 1'b1;
`ifdef GYRO_BIAS_EN
                        if (!r_cal_done) begin
                            r_acc_x   <= r_acc_x + 20'(w_raw_x);
                            r_acc_y   <= r_acc_y + 20'(w_raw_y);
                            r_acc_z   <= r_acc_z + 20'(w_raw_z);
                            r_cal_cnt <= r_cal_cnt + 4'd1;
                            if (r_cal_cnt == 4'd15) r_cal_done <= 1'b1;
                        end else begin
                            r_gx    <= subSat(w_raw_x, w_bias_x);
                            r_gy    <= subSat(w_raw_y, w_bias_y);
                            r_gz    <= subSat(w_raw_z, w_bias_z);
                            r_valid <= 1'b1;
                        end
`else
                        r_gx    <= w_raw_x;
                        r_gy    <= w_raw_y;
                        r_gz    <= w_raw_z;
                        r_valid <= 1'b1;
`endif
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
